multiplier: RTL and testbench
=============================

Name: multiplier

Overview:
- Sequential shift-add unsigned multiplier. It is the inverse-operation companion to the restoring divider in the arithmetic datapath.
- Uses the same level-enable start, Busy/Ready status and Take acknowledge handshake as the divider, so the control FSM can drive either unit the same way.
- Produces a full-width (2*WIDTH) product. Computes one multiplier bit per clock.

Parameters:
- WIDTH, 12, operand bit width; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  level start/enable; low aborts a running operation.
- Multiplicand  input  WIDTH  operand A, sampled at the capture edge.
- Multiplier  input  WIDTH  operand B, sampled at the capture edge.
- Take  input  1  consumer acknowledge; clears Ready.
- Res  output  2*WIDTH  registered product A*B; holds until the next completion or reset.
- Busy  output  1  high while an operation is running.
- Ready  output  1  high from completion until Take, a new capture, or reset.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-operation): Res=0, Busy=0, Ready=0, state IDLE, internal A/B/acc/cnt=0, armed=1.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1.
  - HOLD: Busy=0; completed, waiting for en to drop.
- IDLE: if en=1 and armed=1 at an edge (capture edge C):
  - Load A_reg (2*WIDTH, zero-extended) <= Multiplicand, B_reg <= Multiplier, acc <= 0, cnt <= 0.
  - Busy <= 1, Ready <= 0, go to RUN.
- RUN, each edge:
  - acc <= acc + (B_reg[0] ? A_reg : 0).
  - A_reg <= A_reg << 1; B_reg <= B_reg >> 1; cnt <= cnt + 1.
  - Width rule: acc is 2*WIDTH bits; no overflow is possible.
  - On the last iteration (cnt == WIDTH-1): Res <= final acc (including this cycle's add), Ready <= 1, Busy <= 0, armed <= 0, go to HOLD.
  - Latency: Res/Ready valid after edge C+WIDTH; Busy is high for exactly WIDTH cycles.
- HOLD: stays until en=0 is sampled, then armed <= 1 and go to IDLE. Holding en high never restarts a finished operation.
- Abort: en=0 sampled in RUN -> IDLE, Busy <= 0, armed <= 1. Ready stays 0 and Res keeps its previous value.
- Ready clearing:
  - Ready=1 and Take=1 at an edge -> Ready <= 0; Res unchanged.
  - Take while Ready=0 is ignored.
  - Take on the same edge that sets Ready has no effect; setting Ready wins.
- New capture while Ready=1: the capture clears Ready, and Take on that edge is irrelevant.
- Operand changes after the capture edge have no effect on the running operation.
- Zero operands need no special case. Without the optional feature, the result is 0 after WIDTH cycles.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: RUN also completes on the current edge when (B_reg >> 1) == 0, i.e. no multiplier bits remain.
  - Latency = max(1, index of the highest set bit of Multiplier + 1) cycles.
  - Multiplier=0 or 1 -> Ready after C+1.
  - All other rules (HOLD, Take, abort) are unchanged.
- Undefined: latency is always exactly WIDTH cycles, independent of operand values.

Test Plan:
- Reset mid-run: start 25*40, assert rst_n=0 at C+5 -> Busy=0, Ready=0, Res=0 immediately, before the next clk edge; no completion follows.
- Basic: Multiplicand=25, Multiplier=40, en held high -> Busy high for 12 cycles, Ready=1 and Res=1000 after C+12; no restart while en stays high.
- Max operands: 4095*4095 -> Res=16769025 (0xFFE001) after C+12. Also 4095*0 -> Res=0 after C+12 with the macro undefined.
- Handshake: after Ready, pulse Take=1 for one cycle -> Ready=0 next edge, Res holds 1000. Drop en one cycle, raise it with 7*9 -> new capture, Res=63 after 12 cycles.
- Abort: run 100*200 to completion (Res=20000), start 3*3, drop en at C+5 -> Busy=0 next edge, Ready=0, Res stays 20000. Re-raise en -> a fresh capture occurs.
- Early termination (macro defined): 100*5 -> Res=500, Ready after C+3. 123*0 -> Res=0 after C+1. 1*2048 -> Res=2048 after C+12. With the macro undefined, all three take 12 cycles.

Source files
------------

// File: rtl/multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock, 2*WIDTH-bit product,
// level-enable start with Busy/Ready/Take handshake. Define MULT_EARLY_TERM_EN for early termination.
module multiplier #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  input  logic               Take,
  output logic [2*WIDTH-1:0] Res,
  output logic               Busy,
  output logic               Ready
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [PW-1:0]   acc_r, acc_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            armed_r, armed_s;
  logic [PW-1:0]   res_r, res_s;
  logic            busy_r, busy_s;
  logic            ready_r, ready_s;
  logic [PW-1:0]   sum_s;
  logic            last_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {PW{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {PW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      armed_r <= 1'b1;
      res_r   <= {PW{1'b0}};
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      a_r     <= a_s;
      b_r     <= b_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      armed_r <= armed_s;
      res_r   <= res_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
    end
  end

  // Next-state, datapath and status logic
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    armed_s = armed_r;
    res_s   = res_r;
    busy_s  = busy_r;
    // Take clears Ready; a completion below overrides this, so setting wins.
    ready_s = ready_r & ~Take;
    sum_s   = acc_r + (b_r[0] ? a_r : {PW{1'b0}});
`ifdef MULT_EARLY_TERM_EN
    last_s  = (cnt_r == LAST_CNT) || ((b_r >> 1) == {WIDTH{1'b0}});
`else
    last_s  = (cnt_r == LAST_CNT);
`endif

    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (en && armed_r) begin
          a_s     = {{WIDTH{1'b0}}, Multiplicand};
          b_s     = Multiplier;
          acc_s   = {PW{1'b0}};
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b1;
          ready_s = 1'b0;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          busy_s  = 1'b0;
          armed_s = 1'b1;
          state_s = IDLE;
        end else begin
          acc_s = sum_s;
          a_s   = a_r << 1;
          b_s   = b_r >> 1;
          cnt_s = cnt_r + CW'(1);
          if (last_s) begin
            res_s   = sum_s;
            ready_s = 1'b1;
            busy_s  = 1'b0;
            armed_s = 1'b0;
            state_s = HOLD;
          end else begin
            state_s = RUN;
          end
        end
      end
      HOLD: begin
        busy_s = 1'b0;
        // Only a sampled low en re-arms, so a held en never restarts.
        if (!en) begin
          armed_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        busy_s  = 1'b0;
        armed_s = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  assign Res   = res_r;
  assign Busy  = busy_r;
  assign Ready = ready_r;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the shift-add multiplier; expected latencies
// follow MULT_EARLY_TERM_EN when the bench is compiled with it.
module tb_multiplier;

  localparam int W = 12;
  localparam bit ET =
`ifdef MULT_EARLY_TERM_EN
    1'b1;
`else
    1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           Take;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] res;
  logic           busy;
  logic           ready;

  int checks = 0;
  int errors = 0;

  multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .Multiplicand(mcand),
    .Multiplier(mplier),
    .Take(Take),
    .Res(res),
    .Busy(busy),
    .Ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
    int l;
    l = 1;
    for (int i = 0; i < W; i++) begin
      if (b[i]) l = i + 1;
    end
    return ET ? l : W;
  endfunction

  // Drop en for a cycle, capture a*b (with Take asserted on the capture edge),
  // scramble the operands, then check Busy/Ready around the expected completion.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [31:0] exp_res);
    int lat;
    lat = exp_lat(b);
    en = 1'b0;
    step(1);
    mcand = a;
    mplier = b;
    en = 1'b1;
    Take = 1'b1;
    step(1);
    Take = 1'b0;
    chk({tag, ":busy@C"}, {31'd0, busy}, 32'd1);
    chk({tag, ":ready@C"}, {31'd0, ready}, 32'd0);
    mcand = ~a;
    mplier = ~b;
    if (lat > 1) begin
      step(lat - 1);
      chk({tag, ":busy@last-1"}, {31'd0, busy}, 32'd1);
      chk({tag, ":ready@last-1"}, {31'd0, ready}, 32'd0);
    end
    step(1);
    chk({tag, ":busy@done"}, {31'd0, busy}, 32'd0);
    chk({tag, ":ready@done"}, {31'd0, ready}, 32'd1);
    chk({tag, ":res"}, {8'd0, res}, exp_res);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    Take = 1'b0;
    mcand = 12'd0;
    mplier = 12'd0;
    step(3);
    chk("reset:res", {8'd0, res}, 32'd0);
    chk("reset:busy", {31'd0, busy}, 32'd0);
    chk("reset:ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("idle:busy", {31'd0, busy}, 32'd0);

    // Basic run, then en held high must not restart
    run_op("25x40", 12'd25, 12'd40, 32'd1000);
    step(5);
    chk("hold:busy", {31'd0, busy}, 32'd0);
    chk("hold:ready", {31'd0, ready}, 32'd1);
    chk("hold:res", {8'd0, res}, 32'd1000);

    // Take handshake
    Take = 1'b1;
    step(1);
    Take = 1'b0;
    chk("take:ready", {31'd0, ready}, 32'd0);
    chk("take:res", {8'd0, res}, 32'd1000);
    Take = 1'b1;
    step(1);
    Take = 1'b0;
    chk("take_idle:ready", {31'd0, ready}, 32'd0);
    chk("take_idle:res", {8'd0, res}, 32'd1000);

    run_op("7x9", 12'd7, 12'd9, 32'd63);
    run_op("4095x4095", 12'd4095, 12'd4095, 32'h00FF_E001);
    run_op("4095x0", 12'd4095, 12'd0, 32'd0);
    run_op("100x200", 12'd100, 12'd200, 32'd20000);

    // Abort mid-run
    en = 1'b0;
    step(1);
    mcand = 12'd3;
    mplier = ET ? 12'd2048 : 12'd3;
    en = 1'b1;
    step(1);
    chk("abort:busy@C", {31'd0, busy}, 32'd1);
    step(4);
    en = 1'b0;
    step(1);
    chk("abort:busy", {31'd0, busy}, 32'd0);
    chk("abort:ready", {31'd0, ready}, 32'd0);
    chk("abort:res", {8'd0, res}, 32'd20000);
    en = 1'b1;
    step(1);
    chk("recapture:busy", {31'd0, busy}, 32'd1);
    en = 1'b0;
    step(1);
    chk("abort2:busy", {31'd0, busy}, 32'd0);
    step(3);
    chk("abort2:ready", {31'd0, ready}, 32'd0);
    chk("abort2:res", {8'd0, res}, 32'd20000);

    // Early-termination vectors (full latency without the feature)
    run_op("100x5", 12'd100, 12'd5, 32'd500);
    run_op("123x0", 12'd123, 12'd0, 32'd0);
    run_op("1x2048", 12'd1, 12'd2048, 32'd2048);

    // Take on the completion edge: setting Ready wins
    en = 1'b0;
    step(1);
    mcand = 12'd2;
    mplier = 12'd3;
    en = 1'b1;
    step(1);
    step(exp_lat(12'd3) - 1);
    chk("take_race:ready@last-1", {31'd0, ready}, 32'd0);
    Take = 1'b1;
    step(1);
    Take = 1'b0;
    chk("take_race:ready", {31'd0, ready}, 32'd1);
    chk("take_race:res", {8'd0, res}, 32'd6);
    Take = 1'b1;
    step(1);
    Take = 1'b0;
    chk("take_after:ready", {31'd0, ready}, 32'd0);

    // Asynchronous reset mid-run clears outputs before the next edge
    en = 1'b0;
    step(1);
    mcand = 12'd25;
    mplier = 12'd40;
    en = 1'b1;
    step(1);
    step(4);
    chk("rst_mid:busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("rst_mid:busy", {31'd0, busy}, 32'd0);
    chk("rst_mid:ready", {31'd0, ready}, 32'd0);
    chk("rst_mid:res", {8'd0, res}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(15);
    chk("rst_after:busy", {31'd0, busy}, 32'd0);
    chk("rst_after:ready", {31'd0, ready}, 32'd0);
    chk("rst_after:res", {8'd0, res}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
